// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the unified instruction/data memory port arbiter:
//   the FSM state encoding and the helper that sizes the latency counter.
//   The counter width is CNT_W = $clog2(MEM_LAT+1). The module computes it
//   from its own MEM_LAT parameter through cnt_width().
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_e;

    // Latency used when the arbiter is instantiated without overrides.
    localparam int MEM_LAT_DEFAULT = 1;

    // Width that holds the value MEM_LAT. Latencies below 1 are illegal.
    // They are clamped here so that the width never collapses to zero.
    function automatic int cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(MEM_LAT_DEFAULT);

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported unified memory between the IF stage (fetch)
//   and the MEM stage (loads/stores). The port is granted to one requester
//   at a time, and the FSM waits out the fixed read latency MEM_LAT.
//
//   Ports
//     clk, rst                    clock, synchronous active-high reset
//     if_req/if_addr/if_kill      fetch request, address, discard-stale-fetch
//     if_ack/if_rdata             fetch done pulse, registered instruction
//     d_req/d_we/d_addr/d_wdata   data request (store when d_we=1)
//     d_ack/d_rdata               data done pulse, registered load data
//     mem_en/mem_we/mem_addr/
//     mem_wdata/mem_rdata         memory side, one mem_en cycle per access
//     if_stall/d_stall            combinational req & ~ack for pipeline control
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              d_stall
);
    import mem_port_arbiter_pkg::*;

    localparam int              CNT_W    = cnt_width(MEM_LAT);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    // A requester acked this cycle still shows its req, so it is masked out.
    // A fetch that is being killed this cycle is not worth starting.
    logic d_wants, f_wants, grant_d, grant_f, access_done;

    assign d_wants     = d_req & ~d_ack_q;
    assign f_wants     = if_req & ~if_ack_q & ~if_kill;
    assign grant_d     = (state_q == ST_IDLE) & d_wants;
    assign grant_f     = (state_q == ST_IDLE) & ~d_wants & f_wants;
    // A counter value of 1 marks the cycle in which mem_rdata is valid.
    assign access_done = (state_q != ST_IDLE) & (cnt_q == CNT_ONE);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        unique case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (grant_d) begin
                    state_d = ST_DATA;
                    cnt_d   = LAT_INIT;
                end else if (grant_f) begin
                    state_d = ST_FETCH;
                    cnt_d   = LAT_INIT;
                end
            end
            ST_FETCH: begin
                cnt_d = cnt_q - CNT_ONE;
                // The memory cannot cancel, so a kill only marks the fetch stale.
                if (if_kill) begin
                    drop_d = 1'b1;
                end
                if (access_done) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q - CNT_ONE;
                if (access_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                drop_d  = 1'b0;
            end
        endcase
    end

    // ---------------- output logic (next values of registered outputs) ----
    always_comb begin
        mem_en_d    = grant_d | grant_f;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (grant_d) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
        end else if (grant_f) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
        end

        // A kill seen in the completion cycle counts as well as an earlier one.
        if_ack_d   = (state_q == ST_FETCH) & access_done & ~(drop_q | if_kill);
        d_ack_d    = (state_q == ST_DATA) & access_done;
        if_rdata_d = if_ack_d ? mem_rdata : if_rdata_q;
        // A store has no read data, so d_rdata keeps the last load result.
        d_rdata_d  = (d_ack_d & ~mem_we_q) ? mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    assign if_stall  = if_req & ~if_ack_q;
    assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. u1 runs with MEM_LAT=1 and u3 runs with
// MEM_LAT=3. Both instances share the request inputs. u1 is driven from a
// per-cycle vector table. u3 is driven by hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_kill = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;

    logic        if_ack1, d_ack1, mem_en1, mem_we1, if_stall1, d_stall1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_ack3, d_ack3, mem_en3, mem_we3, if_stall3, d_stall3;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic        en3_d1, en3_d2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Memory contents used by the bench.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0200: return 32'h00A0_0113;
            32'h0000_2000: return 32'h1234_5678;
            default:       return a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    // Read data is driven only in the one cycle in which it is valid.
    // At any other time the bus carries a garbage pattern.
    assign mem_rdata1 = mem_en1 ? mem_f(mem_addr1) : 32'hBAD1_BAD1;
    always @(posedge clk) begin
        en3_d1 <= mem_en3;
        en3_d2 <= en3_d1;
    end
    assign mem_rdata3 = en3_d2 ? mem_f(mem_addr3) : 32'hBAD3_BAD3;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ack(if_ack1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .if_stall(if_stall1), .d_stall(d_stall1)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ack(if_ack3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
        .if_stall(if_stall3), .d_stall(d_stall3)
    );

    typedef struct {
        logic        rst, if_req, if_kill, d_req, d_we;
        logic [31:0] if_addr, d_addr, d_wdata;
        logic        chk, full;
        logic        e_if_ack, e_d_ack, e_mem_en, e_mem_we, e_if_stall, e_d_stall;
        logic [31:0] e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata;
    } vec_t;

    vec_t tbl[$];

    // ib = {rst, if_req, if_kill, d_req, d_we}; ctl = {chk, full};
    // eb = {if_ack, d_ack, mem_en, mem_we, if_stall, d_stall}
    function automatic vec_t v(input logic [4:0] ib, input logic [31:0] ia, da, dw,
                               input logic [1:0] ctl, input logic [5:0] eb,
                               input logic [31:0] eir, edr, ema, emw);
        vec_t r;
        {r.rst, r.if_req, r.if_kill, r.d_req, r.d_we} = ib;
        r.if_addr = ia; r.d_addr = da; r.d_wdata = dw;
        {r.chk, r.full} = ctl;
        {r.e_if_ack, r.e_d_ack, r.e_mem_en, r.e_mem_we, r.e_if_stall, r.e_d_stall} = eb;
        r.e_if_rdata = eir; r.e_d_rdata = edr; r.e_mem_addr = ema; r.e_mem_wdata = emw;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One cycle on the MEM_LAT=3 instance. The inputs are applied after the
    // edge, and the outputs of the same cycle are checked before the next edge.
    task automatic step3(input string nm, input logic r, ir, ik, dr,
                         input logic [31:0] ia, da,
                         input logic e_ia, e_da, e_en,
                         input logic [31:0] e_ma, e_ird, e_drd);
        @(posedge clk);
        #2;
        rst = r; if_req = ir; if_kill = ik; d_req = dr; d_we = 1'b0;
        if_addr = ia; d_addr = da; d_wdata = '0;
        #2;
        $display("%s: if_ack=%b d_ack=%b mem_en=%b mem_addr=%h if_rdata=%h d_rdata=%h",
                 nm, if_ack3, d_ack3, mem_en3, mem_addr3, if_rdata3, d_rdata3);
        if (!r) begin
            check({nm, ".if_ack"},   32'(if_ack3), 32'(e_ia));
            check({nm, ".d_ack"},    32'(d_ack3),  32'(e_da));
            check({nm, ".mem_en"},   32'(mem_en3), 32'(e_en));
            check({nm, ".if_rdata"}, if_rdata3, e_ird);
            check({nm, ".d_rdata"},  d_rdata3,  e_drd);
            if (e_en) check({nm, ".mem_addr"}, mem_addr3, e_ma);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- MEM_LAT=1 vector table: one row per cycle ----
        tbl.push_back(v(5'b10000, 0, 0, 0, 2'b00, 6'b000000, 0, 0, 0, 0));                          // 0 reset
        tbl.push_back(v(5'b00000, 0, 0, 0, 2'b11, 6'b000000, 0, 0, 0, 0));                          // 1 reset values
        tbl.push_back(v(5'b01000, 'h100, 0, 0, 2'b10, 6'b000010, 0, 0, 0, 0));                     // 2 fetch c0
        tbl.push_back(v(5'b01000, 'h100, 0, 0, 2'b10, 6'b001010, 0, 0, 'h100, 0));                  // 3 fetch c1
        tbl.push_back(v(5'b01000, 'h100, 0, 0, 2'b10, 6'b100000, 'h0050_0093, 0, 0, 0));            // 4 if_ack
        tbl.push_back(v(5'b00000, 0, 0, 0, 2'b10, 6'b000000, 'h0050_0093, 0, 0, 0));                // 5
        tbl.push_back(v(5'b01010, 'h300, 'h2000, 0, 2'b10, 6'b000011, 'h0050_0093, 0, 0, 0));      // 6 collision c0
        tbl.push_back(v(5'b01010, 'h300, 'h2000, 0, 2'b10, 6'b001011, 'h0050_0093, 0, 'h2000, 0));  // 7 data mem_en
        tbl.push_back(v(5'b01010, 'h300, 'h2000, 0, 2'b10, 6'b010010, 'h0050_0093, 'h1234_5678, 0, 0)); // 8 d_ack
        tbl.push_back(v(5'b01000, 'h300, 0, 0, 2'b10, 6'b001010, 'h0050_0093, 'h1234_5678, 'h300, 0)); // 9 fetch mem_en
        tbl.push_back(v(5'b01000, 'h300, 0, 0, 2'b10, 6'b100000, 'hA5A5_A6A5, 'h1234_5678, 0, 0));  // 10 if_ack
        tbl.push_back(v(5'b00000, 0, 0, 0, 2'b10, 6'b000000, 'hA5A5_A6A5, 'h1234_5678, 0, 0));      // 11
        tbl.push_back(v(5'b00011, 0, 'h2004, 'hDEAD_BEEF, 2'b10, 6'b000001, 'hA5A5_A6A5, 'h1234_5678, 0, 0)); // 12 store c0
        tbl.push_back(v(5'b00011, 0, 'h2004, 'hDEAD_BEEF, 2'b10, 6'b001101, 'hA5A5_A6A5, 'h1234_5678, 'h2004, 'hDEAD_BEEF)); // 13
        tbl.push_back(v(5'b00011, 0, 'h2004, 'hDEAD_BEEF, 2'b10, 6'b010000, 'hA5A5_A6A5, 'h1234_5678, 0, 0)); // 14 d_ack
        tbl.push_back(v(5'b00000, 0, 0, 0, 2'b10, 6'b000000, 'hA5A5_A6A5, 'h1234_5678, 0, 0));      // 15
        tbl.push_back(v(5'b01000, 'h104, 0, 0, 2'b10, 6'b000010, 'hA5A5_A6A5, 'h1234_5678, 0, 0));  // 16 kill c0
        tbl.push_back(v(5'b01100, 'h104, 0, 0, 2'b10, 6'b001010, 'hA5A5_A6A5, 'h1234_5678, 'h104, 0)); // 17 kill pulse
        tbl.push_back(v(5'b01000, 'h200, 0, 0, 2'b10, 6'b000010, 'hA5A5_A6A5, 'h1234_5678, 0, 0));  // 18 no ack
        tbl.push_back(v(5'b01000, 'h200, 0, 0, 2'b10, 6'b001010, 'hA5A5_A6A5, 'h1234_5678, 'h200, 0)); // 19
        tbl.push_back(v(5'b01000, 'h200, 0, 0, 2'b10, 6'b100000, 'h00A0_0113, 'h1234_5678, 0, 0));  // 20 if_ack
        tbl.push_back(v(5'b01100, 'h300, 0, 0, 2'b10, 6'b000010, 'h00A0_0113, 'h1234_5678, 0, 0));  // 21 req+kill idle
        tbl.push_back(v(5'b00000, 0, 0, 0, 2'b10, 6'b000000, 'h00A0_0113, 'h1234_5678, 0, 0));      // 22 no grant
        tbl.push_back(v(5'b00010, 0, 'h2000, 0, 2'b10, 6'b000001, 'h00A0_0113, 'h1234_5678, 0, 0)); // 23 load c0
        tbl.push_back(v(5'b10010, 0, 'h2000, 0, 2'b10, 6'b001001, 'h00A0_0113, 'h1234_5678, 'h2000, 0)); // 24 rst
        tbl.push_back(v(5'b00000, 0, 0, 0, 2'b11, 6'b000000, 0, 0, 0, 0));                          // 25 reset values
        tbl.push_back(v(5'b00010, 0, 'h2000, 0, 2'b10, 6'b000001, 0, 0, 0, 0));                     // 26 new load
        tbl.push_back(v(5'b00010, 0, 'h2000, 0, 2'b10, 6'b001001, 0, 0, 'h2000, 0));                // 27
        tbl.push_back(v(5'b00010, 0, 'h2000, 0, 2'b10, 6'b010000, 0, 'h1234_5678, 0, 0));           // 28 d_ack
        tbl.push_back(v(5'b00000, 0, 0, 0, 2'b10, 6'b000000, 0, 'h1234_5678, 0, 0));                // 29

        foreach (tbl[i]) begin
            @(posedge clk);
            #2;
            rst = tbl[i].rst; if_req = tbl[i].if_req; if_kill = tbl[i].if_kill;
            d_req = tbl[i].d_req; d_we = tbl[i].d_we; if_addr = tbl[i].if_addr;
            d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
            #2;
            $display("vec %0d: if_ack=%b if_rdata=%h d_ack=%b d_rdata=%h mem_en=%b mem_we=%b mem_addr=%h stall=%b%b",
                     i, if_ack1, if_rdata1, d_ack1, d_rdata1, mem_en1, mem_we1, mem_addr1, if_stall1, d_stall1);
            if (tbl[i].chk) begin
                check($sformatf("v%0d.if_ack", i),   32'(if_ack1),   32'(tbl[i].e_if_ack));
                check($sformatf("v%0d.d_ack", i),    32'(d_ack1),    32'(tbl[i].e_d_ack));
                check($sformatf("v%0d.mem_en", i),   32'(mem_en1),   32'(tbl[i].e_mem_en));
                check($sformatf("v%0d.if_stall", i), 32'(if_stall1), 32'(tbl[i].e_if_stall));
                check($sformatf("v%0d.d_stall", i),  32'(d_stall1),  32'(tbl[i].e_d_stall));
                check($sformatf("v%0d.if_rdata", i), if_rdata1, tbl[i].e_if_rdata);
                check($sformatf("v%0d.d_rdata", i),  d_rdata1,  tbl[i].e_d_rdata);
                // The access fields are meaningful only while mem_en is high,
                // except in the reset-value rows.
                if (tbl[i].full || tbl[i].e_mem_en) begin
                    check($sformatf("v%0d.mem_we", i),   32'(mem_we1), 32'(tbl[i].e_mem_we));
                    check($sformatf("v%0d.mem_addr", i), mem_addr1, tbl[i].e_mem_addr);
                end
                if (tbl[i].full || (tbl[i].e_mem_en && tbl[i].e_mem_we))
                    check($sformatf("v%0d.mem_wdata", i), mem_wdata1, tbl[i].e_mem_wdata);
            end
        end

        // ---- MEM_LAT=3: load timing ----
        //     nm        rst ir ik dr ia     da       ia da en ma       ird           drd
        step3("L3.rst", 1, 0, 0, 0, 0,     0,       0, 0, 0, 0,       0,            0);
        step3("L3.c0",  0, 0, 0, 1, 0,     'h2000,  0, 0, 0, 0,       0,            0);
        step3("L3.c1",  0, 0, 0, 1, 0,     'h2000,  0, 0, 1, 'h2000,  0,            0);
        step3("L3.c2",  0, 0, 0, 1, 0,     'h2000,  0, 0, 0, 0,       0,            0);
        step3("L3.c3",  0, 0, 0, 1, 0,     'h2000,  0, 0, 0, 0,       0,            0);
        step3("L3.c4",  0, 0, 0, 1, 0,     'h2000,  0, 1, 0, 0,       0,            'h1234_5678);
        step3("L3.c5",  0, 0, 0, 0, 0,     0,       0, 0, 0, 0,       0,            'h1234_5678);
        // ---- MEM_LAT=3: kill in a middle cycle drops the fetch ----
        step3("K3.c0",  0, 1, 0, 0, 'h104, 0,       0, 0, 0, 0,       0,            'h1234_5678);
        step3("K3.c1",  0, 1, 0, 0, 'h104, 0,       0, 0, 1, 'h104,   0,            'h1234_5678);
        step3("K3.c2",  0, 1, 1, 0, 'h104, 0,       0, 0, 0, 0,       0,            'h1234_5678);
        step3("K3.c3",  0, 0, 0, 0, 0,     0,       0, 0, 0, 0,       0,            'h1234_5678);
        step3("K3.c4",  0, 0, 0, 0, 0,     0,       0, 0, 0, 0,       0,            'h1234_5678);
        step3("K3.c5",  0, 1, 0, 0, 'h200, 0,       0, 0, 0, 0,       0,            'h1234_5678);
        step3("K3.c6",  0, 1, 0, 0, 'h200, 0,       0, 0, 1, 'h200,   0,            'h1234_5678);
        step3("K3.c7",  0, 1, 0, 0, 'h200, 0,       0, 0, 0, 0,       0,            'h1234_5678);
        step3("K3.c8",  0, 1, 0, 0, 'h200, 0,       0, 0, 0, 0,       0,            'h1234_5678);
        step3("K3.c9",  0, 1, 0, 0, 'h200, 0,       1, 0, 0, 0,       'h00A0_0113,  'h1234_5678);
        step3("K3.c10", 0, 0, 0, 0, 0,     0,       0, 0, 0, 0,       'h00A0_0113,  'h1234_5678);
        // ---- MEM_LAT=3: kill during a data access is ignored ----
        step3("D3.c0",  0, 0, 0, 1, 0,     'h2008,  0, 0, 0, 0,       'h00A0_0113,  'h1234_5678);
        step3("D3.c1",  0, 0, 0, 1, 0,     'h2008,  0, 0, 1, 'h2008,  'h00A0_0113,  'h1234_5678);
        step3("D3.c2",  0, 0, 1, 1, 0,     'h2008,  0, 0, 0, 0,       'h00A0_0113,  'h1234_5678);
        step3("D3.c3",  0, 0, 0, 1, 0,     'h2008,  0, 0, 0, 0,       'h00A0_0113,  'h1234_5678);
        step3("D3.c4",  0, 0, 0, 1, 0,     'h2008,  0, 1, 0, 0,       'h00A0_0113,  'hA5A5_85AD);
        step3("D3.c5",  0, 0, 0, 0, 0,     0,       0, 0, 0, 0,       'h00A0_0113,  'hA5A5_85AD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (loads and stores) of the 5-stage pipeline. A small FSM grants the port to one requester at a time and tracks the fixed memory read latency. It returns data with a one-cycle acknowledge pulse and supports discarding a fetch that a taken branch has made stale. Its stall outputs feed the pipeline control logic alongside the load-use stall.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from the mem_en cycle to the cycle mem_rdata is valid; must be ≥1

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request; held until if_ack or if_kill
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_kill  in  1  discard the outstanding fetch (taken branch or flush)
- if_ack  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction, registered
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse; load data valid or store done
- d_rdata  out  DATA_W  load data, registered
- mem_en  out  1  memory access strobe, registered, one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- if_stall  out  1  combinational: if_req & ~if_ack
- d_stall  out  1  combinational: d_req & ~d_ack

## Operation
- FSM states: IDLE, FETCH, DATA.
- In IDLE, the grant is decided at the clock edge:
  - d_req has priority over if_req.
  - The requester acked in the current cycle is ignored, because its req is still high that cycle.
  - if_req is ignored in any cycle where if_kill is high.
- On a grant:
  - mem_en is 1 for exactly the next cycle, and mem_addr, mem_we and mem_wdata are captured.
  - mem_we is 0 for a fetch.
  - The latency counter is loaded with MEM_LAT.
- In FETCH or DATA, the counter decrements each cycle. At the edge ending the cycle in which mem_rdata is valid:
  - mem_rdata is captured into if_rdata or d_rdata. A store captures nothing, and d_rdata holds its value.
  - The matching ack is set, and the FSM returns to IDLE.
- if_kill:
  - Sampled high in any FETCH cycle, it sets a drop flag.
  - A dropped fetch still completes its memory access, because the memory cannot cancel.
  - A dropped fetch never raises if_ack, and if_rdata holds its value.
  - if_kill in the ack cycle has no effect on that ack.
- if_kill during DATA is ignored.
- A store and a load behave identically except for mem_we and the data capture.
- No fairness counter is needed. The MEM stage stalls the pipeline, so data requests cannot starve fetch indefinitely.

## Timing
- Request seen in IDLE at cycle N:
  - mem_en is high in cycle N+1.
  - mem_rdata is sampled at the end of cycle N+MEM_LAT.
  - The ack is high in cycle N+MEM_LAT+1.
  - Total latency is MEM_LAT+2 cycles from the first req cycle, when idle.
- Back-to-back accesses: the arbiter may grant the other requester in the ack cycle, so the next mem_en is in the cycle after the ack. Throughput is one access per MEM_LAT+1 cycles.
- Simultaneous if_req and d_req in IDLE: data is served first. Fetch is granted in the d_ack cycle if if_req is still high.
- Reset values:
  - State is IDLE.
  - mem_en, mem_we, if_ack and d_ack are 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata are 0.
  - The drop flag and the counter are 0.
- rst mid-access: the outstanding access is abandoned, no ack is produced, and the late mem_rdata is ignored.

## Structure
- Shared package holds the state encoding (IDLE/FETCH/DATA) and a counter width constant CNT_W = $clog2(MEM_LAT+1).
- No sub-module; a single module is sufficient.

## Test plan
- Fetch only, MEM_LAT=1:
  - Stimulus: if_req=1 with if_addr=0x100 at cycle 0; memory returns 0x00500093.
  - Required: mem_en in cycle 1 with mem_addr=0x100 and mem_we=0; if_ack in cycle 2 with if_rdata=0x00500093; if_stall high in cycles 0–1.
- Collision:
  - Stimulus: if_req and d_req (load, 0x2000) both high at cycle 0.
  - Required: data is granted first, and d_ack is in cycle 2.
  - Required: fetch mem_en is in cycle 3, and if_ack is in cycle 4.
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF.
  - Required: mem_en=1 and mem_we=1 with these values in cycle 1; d_ack in cycle 2; d_rdata unchanged.
- Kill:
  - Stimulus: fetch at 0x104, with if_kill pulsed in cycle 1.
  - Required: no if_ack, if_rdata unchanged, and the FSM is in IDLE in cycle 3.
  - Required: a fetch of 0x200 requested in cycle 2 gets mem_en in cycle 3 and if_ack in cycle 4.
- MEM_LAT=3:
  - Stimulus: a load at cycle 0.
  - Required: mem_en in cycle 1; data sampled at the end of cycle 3; d_ack in cycle 4.
- Reset mid-access:
  - Stimulus: rst in cycle 1 of a load.
  - Required: no d_ack, all outputs at their reset values in cycle 2, and a new request is served normally afterward.
